vga_scan_ctrl: RTL

Timing sequencer for the VGA sync decoder. It generates the 25 MHz pixel-enable from the 100 MHz board clock and the free-running h_count/v_count scan counters that the sync decoder consumes. It also schedules the once-per-frame game-state update during vertical blanking through a req/ack handshake, so sprite and obstacle logic never changes mid-frame.

---
 rtl/vga_scan_ctrl_if.sv | 24 ++
 rtl/vga_scan_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl_if.sv
// Game-update handshake between the scan controller (master) and the game-state logic (slave).
interface vga_scan_ctrl_if;
    logic upd_req;
    logic upd_ack;
    logic upd_window;
    logic overrun;
    logic ovr_clr;

    modport master (
        output upd_req,
        output upd_window,
        output overrun,
        input  upd_ack,
        input  ovr_clr
    );

    modport slave (
        input  upd_req,
        input  upd_window,
        input  overrun,
        output upd_ack,
        output ovr_clr
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan timing: pixel-enable divider, h/v scan counters and once-per-frame update handshake.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit free-running frame counter output.
module vga_scan_ctrl #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned VD      = 480
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic [9:0]        o_h_count,
    output logic [9:0]        o_v_count,
    output logic              o_pix_tick,
    output logic              o_line_end,
    output logic              o_frame_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]       o_frame_cnt,
`endif
    vga_scan_ctrl_if.master   upd
);
    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIV_W = $clog2(DIV);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    state_e           state_q, state_d;
    logic             upd_req_q, upd_req_d;
    logic             overrun_q, overrun_d;
    logic             frame_start_q;
    logic             tick, h_last, v_last, wrap, win_open, set_ovr;

    assign tick     = i_en && (div_q == DIV_W'(DIV - 1));
    assign h_last   = (h_q == CNT_W'(H_TOTAL - 1));
    assign v_last   = (v_q == CNT_W'(V_TOTAL - 1));
    assign wrap     = tick && h_last && v_last;
    assign win_open = tick && h_last && (v_q == CNT_W'(VD - 1));

    // Divider and scan counters
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (i_en) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // Update FSM; an ack coinciding with the wrap returns straight to IDLE so the next frame still requests
    always_comb begin
        state_d   = state_q;
        set_ovr   = 1'b0;
        unique case (state_q)
            S_IDLE: if (win_open) state_d = S_REQ;
            S_REQ: begin
                if (upd.upd_ack) begin
                    state_d = wrap ? S_IDLE : S_DONE;
                end else if (wrap) begin
                    state_d = S_IDLE;
                    set_ovr = 1'b1;
                end
            end
            S_DONE: if (wrap) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        upd_req_d = (state_d == S_REQ);
        overrun_d = set_ovr ? 1'b1 : (upd.ovr_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            state_q       <= S_IDLE;
            upd_req_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            state_q       <= state_d;
            upd_req_q     <= upd_req_d;
            overrun_q     <= overrun_d;
            frame_start_q <= wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else if (wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

    assign o_h_count      = h_q;
    assign o_v_count      = v_q;
    assign o_pix_tick     = tick;
    assign o_line_end     = tick && h_last;
    assign o_frame_start  = frame_start_q;
    assign upd.upd_req    = upd_req_q;
    assign upd.upd_window = (v_q >= CNT_W'(VD));
    assign upd.overrun    = overrun_q;
endmodule
